// File: rtl/handshake_fifo.sv
// rtl/handshake_fifo.sv - FIFO bridging a four-phase or two-phase req/ack handshake on both sides
module handshake_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_req,
  output logic                       in_ack,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_req,
  input  logic                       out_ack,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);
  localparam bit FOUR_PHASE = (MODE == 0);

  generate
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
      $error("handshake_fifo: MODE must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             accept;
  logic             launch;
  logic             ack_return;
  logic             req_return;
  logic             has_space;
  logic             has_data;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  // Decode accept/launch from registered state only; a launch is suppressed while flushing.
  always_comb begin
    has_space  = (count < FULL_COUNT);
    has_data   = (count != '0);
    accept     = 1'b0;
    launch     = 1'b0;
    ack_return = 1'b0;
    req_return = 1'b0;
    if (FOUR_PHASE) begin
      accept     = in_req & ~in_ack & has_space;
      launch     = ~out_req & ~out_ack & has_data & ~flush;
      ack_return = ~in_req & in_ack;
      req_return = out_req & out_ack;
    end else begin
      accept = (in_req ^ in_ack) & has_space;
      launch = ~(out_req ^ out_ack) & has_data & ~flush;
    end
  end

  // Storage write; a word accepted during flush is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && accept && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Handshake outputs, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ack   <= 1'b0;
      out_req  <= 1'b0;
      out_data <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (accept) begin
        in_ack <= in_req;
      end else if (ack_return) begin
        in_ack <= 1'b0;
      end

      if (launch) begin
        out_data <= mem[rd_ptr];
        out_req  <= ~out_req;
      end else if (req_return) begin
        out_req <= 1'b0;
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) wr_ptr <= bump(wr_ptr);
        if (launch) rd_ptr <= bump(rd_ptr);
        case ({accept, launch})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_handshake_fifo.sv
// tb/tb_handshake_fifo.sv - self-checking bench for handshake_fifo in both handshake modes
module tb_handshake_fifo;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // four-phase instance: WIDTH 3, DEPTH 4
  logic       r0_n, fl0, ireq0, iack0, oreq0, oack0;
  logic [2:0] idat0, odat0, cnt0;
  // two-phase instance: WIDTH 8, DEPTH 3
  logic       r1_n, fl1, ireq1, iack1, oreq1, oack1;
  logic [7:0] idat1, odat1;
  logic [1:0] cnt1;

  handshake_fifo #(.WIDTH(3), .DEPTH(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(r0_n), .flush(fl0), .in_req(ireq0), .in_ack(iack0), .in_data(idat0),
    .out_req(oreq0), .out_ack(oack0), .out_data(odat0), .count(cnt0));

  handshake_fifo #(.WIDTH(8), .DEPTH(3), .MODE(1)) dut1 (
    .clk(clk), .rst_n(r1_n), .flush(fl1), .in_req(ireq1), .in_ack(iack1), .in_data(idat1),
    .out_req(oreq1), .out_ack(oack1), .out_data(odat1), .count(cnt1));

  logic [2:0] sb0[$];
  logic [7:0] sb1[$];
  int launches0 = 0, launches1 = 0;
  int launch_cyc1[$];
  int first_iack0 = -1, first_oreq0 = -1;
  int cntmax0 = 0;
  bit track0 = 0;
  bit en0 = 1, en1 = 1;
  logic seen0 = 0, seen1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Downstream partners: registered, ack follows the req seen one clock earlier.
  initial forever begin
    @(negedge clk);
    if (en0) oack0 = seen0;
    seen0 = oreq0;
    if (en1) oack1 = seen1;
    seen1 = oreq1;
  end

  // Scoreboard monitors: every new request phase on the out side pops one expected word.
  initial begin
    logic p_oreq0, p_iack0, p_oreq1;
    p_oreq0 = 0; p_iack0 = 0; p_oreq1 = 0;
    forever begin
      @(negedge clk);
      if (oreq0 === 1'b1 && p_oreq0 === 1'b0) begin
        launches0++;
        if (first_oreq0 < 0) first_oreq0 = cyc;
        if (sb0.size() == 0) check("dut0 unexpected launch", 32'(odat0), 32'hFFFF_FFFF);
        else check("dut0 out_data", 32'(odat0), 32'(sb0.pop_front()));
      end
      if (iack0 === 1'b1 && p_iack0 === 1'b0 && first_iack0 < 0) first_iack0 = cyc;
      if (track0 && int'(cnt0) > cntmax0) cntmax0 = int'(cnt0);
      if (r1_n === 1'b1 && oreq1 !== p_oreq1) begin
        launches1++;
        launch_cyc1.push_back(cyc);
        if (sb1.size() == 0) check("dut1 unexpected launch", 32'(odat1), 32'hFFFF_FFFF);
        else check("dut1 out_data", 32'(odat1), 32'(sb1.pop_front()));
      end
      p_oreq0 = oreq0; p_iack0 = iack0; p_oreq1 = oreq1;
    end
  end

  task automatic wait_iack0(input logic v);
    int n = 0;
    do begin @(negedge clk); n++; end while (iack0 !== v && n < 100);
    check("dut0 in_ack handshake", 32'(iack0), 32'(v));
  endtask

  task automatic send0(input logic [2:0] d);
    @(negedge clk); ireq0 = 1'b1; idat0 = d;
    wait_iack0(1'b1);
    @(negedge clk); ireq0 = 1'b0;
    wait_iack0(1'b0);
  endtask

  task automatic send1(input logic [7:0] d);
    int n = 0;
    @(negedge clk); ireq1 = ~ireq1; idat1 = d;
    do begin @(negedge clk); n++; end while (iack1 !== ireq1 && n < 100);
    check("dut1 in_ack toggle", 32'(iack1), 32'(ireq1));
  endtask

  task automatic drain0();
    int n = 0;
    while (sb0.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("dut0 drained", 32'(sb0.size()), 32'd0);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    vec_t t34[3];
    vec_t t35[6];
    vec_t t36[10];
    int base;
    t34[0] = '{8'd3, 8'd3}; t34[1] = '{8'd5, 8'd5}; t34[2] = '{8'd6, 8'd6};
    for (int i = 0; i < 6; i++) t35[i] = '{8'(i + 1), 8'(i + 1)};
    for (int i = 0; i < 10; i++) t36[i] = '{8'(8'h11 * i + 8'h07), 8'(8'h11 * i + 8'h07)};

    r0_n = 0; fl0 = 0; ireq0 = 0; idat0 = 0; oack0 = 0;
    r1_n = 0; fl1 = 0; ireq1 = 0; idat1 = 0; oack1 = 0;
    repeat (2) @(negedge clk);
    check("reset in_ack", 32'(iack0), 32'd0);
    check("reset out_req", 32'(oreq0), 32'd0);
    check("reset out_data", 32'(odat0), 32'd0);
    check("reset count", 32'(cnt0), 32'd0);
    check("reset dut1 out_req", 32'(oreq1), 32'd0);
    check("reset dut1 in_ack", 32'(iack1), 32'd0);
    r0_n = 1; r1_n = 1;
    repeat (2) @(negedge clk);

    // four-phase, prompt partners: 3, 5, 6 in order
    track0 = 1;
    for (int i = 0; i < 3; i++) begin
      sb0.push_back(t34[i].dout[2:0]);
      send0(t34[i].din[2:0]);
    end
    drain0();
    track0 = 0;
    check("first out_req after first in_ack", 32'(first_oreq0 - first_iack0), 32'd1);
    check("count peak during streaming", 32'(cntmax0), 32'd1);
    check("count after stream", 32'(cnt0), 32'd0);

    // four-phase, downstream stalled: fill to DEPTH, sixth word waits
    en0 = 0; oack0 = 0;
    base = launches0;
    for (int i = 0; i < 5; i++) begin
      sb0.push_back(t35[i].dout[2:0]);
      send0(t35[i].din[2:0]);
    end
    check("stall count full", 32'(cnt0), 32'd4);
    check("stall out_data holds first", 32'(odat0), 32'd1);
    check("stall out_req pending", 32'(oreq0), 32'd1);
    sb0.push_back(t35[5].dout[2:0]);
    @(negedge clk); ireq0 = 1'b1; idat0 = t35[5].din[2:0];
    repeat (6) @(negedge clk);
    check("full in_ack held low", 32'(iack0), 32'd0);
    check("full count", 32'(cnt0), 32'd4);
    en0 = 1;
    wait_iack0(1'b1);
    @(negedge clk); ireq0 = 1'b0;
    wait_iack0(1'b0);
    drain0();
    check("stall words delivered", 32'(launches0 - base), 32'd6);

    // flush with three stored and a transfer pending downstream
    en0 = 0;
    sb0.push_back(3'd2);
    send0(3'd2); send0(3'd3); send0(3'd4); send0(3'd5);
    check("pre-flush count", 32'(cnt0), 32'd3);
    check("pre-flush out_req", 32'(oreq0), 32'd1);
    @(negedge clk); fl0 = 1;
    @(negedge clk); fl0 = 0;
    check("flush count", 32'(cnt0), 32'd0);
    check("flush out_data kept", 32'(odat0), 32'd2);
    check("flush out_req kept", 32'(oreq0), 32'd1);
    base = launches0;
    en0 = 1;
    repeat (12) @(negedge clk);
    check("flushed transfer completed", 32'(oreq0), 32'd0);
    check("no launch after flush", 32'(launches0 - base), 32'd0);

    // accept coinciding with flush
    @(negedge clk); ireq0 = 1'b1; idat0 = 3'd7; fl0 = 1;
    @(negedge clk);
    check("accept+flush in_ack", 32'(iack0), 32'd1);
    check("accept+flush count", 32'(cnt0), 32'd0);
    fl0 = 0;
    @(negedge clk); ireq0 = 1'b0;
    wait_iack0(1'b0);
    repeat (8) @(negedge clk);
    check("flushed word never launched", 32'(launches0 - base), 32'd0);

    // reset mid-handshake with two stored and out_req pending
    en0 = 0;
    sb0.push_back(3'd1);
    send0(3'd1); send0(3'd2);
    @(negedge clk); ireq0 = 1'b1; idat0 = 3'd3;
    wait_iack0(1'b1);
    check("pre-reset count", 32'(cnt0), 32'd2);
    check("pre-reset out_req", 32'(oreq0), 32'd1);
    @(negedge clk); r0_n = 0; ireq0 = 1'b0;
    @(negedge clk);
    check("mid reset in_ack", 32'(iack0), 32'd0);
    check("mid reset out_req", 32'(oreq0), 32'd0);
    check("mid reset out_data", 32'(odat0), 32'd0);
    check("mid reset count", 32'(cnt0), 32'd0);
    r0_n = 1; oack0 = 0; en0 = 1;
    base = launches0;
    repeat (8) @(negedge clk);
    check("nothing after reset", 32'(launches0 - base), 32'd0);
    check("dut0 scoreboard empty", 32'(sb0.size()), 32'd0);

    // two-phase, back-to-back toggles through a depth-3 ring
    for (int i = 0; i < 10; i++) begin
      sb1.push_back(t36[i].dout);
      send1(t36[i].din);
    end
    begin
      int n = 0;
      while (sb1.size() != 0 && n < 200) begin @(negedge clk); n++; end
    end
    repeat (4) @(negedge clk);
    check("dut1 drained", 32'(sb1.size()), 32'd0);
    check("dut1 launches", 32'(launches1), 32'd10);
    for (int k = 1; k < launch_cyc1.size(); k++)
      check("dut1 launch spacing", 32'(launch_cyc1[k] - launch_cyc1[k-1]), 32'd2);
    check("dut1 final count", 32'(cnt1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/handshake_fifo.md
HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, data bits per transfer (WIDTH >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, storage entries (DEPTH >= 2; any integer, not required to be a power of 2).
REQ-003 The block SHALL have parameter MODE, default 0, handshake protocol (0 = four-phase return-to-zero, 1 = two-phase transition signalling; other values are a elaboration error).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous discard of stored entries.
REQ-007 in_req  input  1  upstream request; in_data valid while the request phase is pending.
REQ-008 in_ack  output  1  upstream acknowledge, registered.
REQ-009 in_data  input  WIDTH  upstream data.
REQ-010 out_req  output  1  downstream request, registered.
REQ-011 out_ack  input  1  downstream acknowledge.
REQ-012 out_data  output  WIDTH  downstream data, registered; stable from out_req change until the transfer completes.
REQ-013 count  output  $clog2(DEPTH+1)  entries stored, excluding the word held in out_data.

Function
REQ-014 All inputs SHALL be sampled only at the rising clk edge; there is no combinational path from any input to any output.
REQ-015 Accept condition: MODE 0 = in_req & ~in_ack & (count < DEPTH); MODE 1 = (in_req != in_ack) & (count < DEPTH).
REQ-016 On accept, the block SHALL write in_data at the write pointer and advance the pointer, and in_ack SHALL take the value of in_req (MODE 0: 1; MODE 1: toggle).
REQ-017 In MODE 0, when ~in_req & in_ack, in_ack SHALL return to 0 at the next edge, independent of count.
REQ-018 Launch condition: MODE 0 = ~out_req & ~out_ack & (count > 0); MODE 1 = (out_req == out_ack) & (count > 0).
REQ-019 On launch, out_data SHALL load the entry at the read pointer and the read pointer SHALL advance; out_req SHALL go to 1 in MODE 0 and toggle in MODE 1.
REQ-020 In MODE 0, when out_req & out_ack, out_req SHALL return to 0 at the next edge; no further launch occurs until out_ack is sampled 0.
REQ-021 Full and empty decisions SHALL use count as registered before the edge, with no pass-through. A launch that frees the last slot does not permit an accept at the same edge.
REQ-022 Accept and launch at the same edge SHALL both occur; count is unchanged.
REQ-023 Minimum latency SHALL be as follows: accept at edge E, then out_req changes at E+1 at the earliest; sustained throughput is one transfer per 4 clocks in MODE 0 and one per 2 clocks in MODE 1, with prompt partners.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 When full (count == DEPTH), in_ack SHALL hold its current value; in MODE 0, a pending in_req waits and is not lost.
REQ-026 When empty, out_req and out_data SHALL hold.
REQ-027 Flush = 1 SHALL set the pointers and count to 0 at that edge.
REQ-028 Flush SHALL NOT alter out_req, out_data or any in-flight downstream transfer.
REQ-029 An accept coinciding with flush SHALL still update in_ack, completing the upstream handshake, but the datum SHALL be discarded and count SHALL read 0.
REQ-030 A launch coinciding with flush SHALL NOT occur.

Reset
REQ-031 While rst_n = 0 at an edge, in_ack, out_req, out_data, count and both pointers SHALL be set to 0; memory contents are don't-care.
REQ-032 Reset SHALL take priority over flush, accept and launch.
REQ-033 Reset mid-handshake SHALL abandon the transfer; the system SHALL reset both partners together. A MODE 0 upstream still holding in_req = 1 after reset is accepted again as a new transfer.

Verification
REQ-034 The bench SHALL cover MODE 0, DEPTH 4, WIDTH 3: send 3, 5, 6 with prompt out_ack -> out_data sequence 3, 5, 6; first out_req rises 1 clk after first in_ack rises; count never exceeds 1.
REQ-035 The bench SHALL cover MODE 0, out_ack held 0, 6 words offered -> first word launched to out_data, then 4 accepted, count = 4, in_ack stays 0 on the 6th; releasing out_ack -> 6th accepted, all 6 words delivered in order.
REQ-036 The bench SHALL cover MODE 1, WIDTH 8, DEPTH 3: 10 back-to-back toggles with immediate ack -> 10 words in order, one per 2 clk steady state, pointers wrap correctly.
REQ-037 The bench SHALL cover flush asserted with count = 3 and out_req = 1 pending -> count = 0 next edge, out_data unchanged, the pending out transfer completes, no further launches.
REQ-038 The bench SHALL cover accept and flush at the same edge -> in_ack = 1, count = 0, the word never appears on out_data.
REQ-039 The bench SHALL cover rst_n = 0 for 1 clk with count = 2 and out_req = 1 -> in_ack = 0, out_req = 0, out_data = 0, count = 0 at that edge.
